cpm_skid_reg: RTL and testbench

- Handshaked counterpart to the free-running clearable CPM pipeline register.
- Accepts data from an upstream CPM stage with valid/ready and presents it to a downstream consumer that can apply backpressure.
- Two-entry skid buffer: full throughput, 1-cycle latency, no combinational path from OutRdy to InRdy.
- Synchronous Clear flushes the stage, matching the clear semantics of the plain CPM register.

---
 rtl/cpm_skid_reg.sv | 105 ++++++++++
 tb/tb_cpm_skid_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpm_skid_reg.sv
// Two-entry handshaked CPM register stage: full throughput, one cycle of latency.
// InRdy depends only on registered state, so OutRdy never reaches InRdy combinationally.
module cpm_skid_reg #(
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic          Clear,
  input  logic          InVld,
  output logic          InRdy,
  input  logic [DW-1:0] DataIn,
  output logic          OutVld,
  input  logic          OutRdy,
  output logic [DW-1:0] DataOut,
  output logic [1:0]    Level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] main_p1;
  logic [DW-1:0] skid_p1;
  logic          in_fire;
  logic          out_fire;
  logic          load_main;
  logic          main_from_skid;
  logic          load_skid;

  assign OutVld   = (state != EMPTY);
  assign InRdy    = (state != FULL);
  assign DataOut  = main_p1;
  assign Level    = state;
  assign in_fire  = InVld & InRdy;
  assign out_fire = OutVld & OutRdy;

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state <= EMPTY;
    end else if (Clear) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          // main keeps its stale word; OutVld masks it
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Stage 1: head (main) and overflow (skid) entries
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else if (Clear) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main) begin
        main_p1 <= main_from_skid ? skid_p1 : DataIn;
      end
      if (load_skid) begin
        skid_p1 <= DataIn;
      end
    end
  end

endmodule

// File: tb/tb_cpm_skid_reg.sv
// Scoreboard bench for cpm_skid_reg: directed handshake scenarios plus a long random stream.
module tb_cpm_skid_reg;

  logic       Clk = 1'b0;
  logic       Rstn = 1'b0;
  logic       Clear = 1'b0;
  logic       InVld = 1'b0;
  logic       InRdy;
  logic [7:0] DataIn = 8'h00;
  logic       OutVld;
  logic       OutRdy = 1'b0;
  logic [7:0] DataOut;
  logic [1:0] Level;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  bit         rst_evt = 1'b0;
  bit         hold = 1'b0;
  bit         prev_clear = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         done = 1'b0;

  cpm_skid_reg #(.DW(8)) dut (
    .Clk    (Clk),
    .Rstn   (Rstn),
    .Clear  (Clear),
    .InVld  (InVld),
    .InRdy  (InRdy),
    .DataIn (DataIn),
    .OutVld (OutVld),
    .OutRdy (OutRdy),
    .DataOut(DataOut),
    .Level  (Level)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Offer one word and wait until the stage takes it; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    InVld  = 1'b1;
    DataIn = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (InRdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 200 cycles", d);
      InVld = 1'b0;
    end else begin
      @(posedge Clk);
      exp_q.push_back(d);
      #1;
      InVld = 1'b0;
    end
  endtask

  always @(negedge Rstn) rst_evt = 1'b1;

  // Monitor: pops on every output transfer and checks that a stalled word holds still.
  always @(negedge Clk) begin
    if (rst_evt) begin
      rst_evt = 1'b0;
    end else if (hold && !prev_clear) begin
      chk("stall_vld", int'(OutVld), 1);
      chk("stall_data", int'(DataOut), int'(prev_data));
    end
    if (Rstn && OutVld && OutRdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%0h with nothing expected at %0t", DataOut, $time);
      end else begin
        chk("out_data", int'(DataOut), int'(exp_q.pop_front()));
      end
    end
    hold       = Rstn && OutVld && !OutRdy;
    prev_data  = DataOut;
    prev_clear = Clear;
  end

  initial begin
    // Reset values
    #3;
    chk("rst_outvld", int'(OutVld), 0);
    chk("rst_dataout", int'(DataOut), 0);
    chk("rst_inrdy", int'(InRdy), 1);
    chk("rst_level", int'(Level), 0);
    #9 Rstn = 1'b1;
    step();

    // Streaming at full rate
    OutRdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      chk("stream_data", int'(DataOut), i);
      chk("stream_level", int'(Level), 1);
      chk("stream_inrdy", int'(InRdy), 1);
    end
    repeat (3) step();
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure
    OutRdy = 1'b0;
    send(8'hA1);
    send(8'hA2);
    chk("bp_level", int'(Level), 2);
    chk("bp_inrdy", int'(InRdy), 0);
    chk("bp_data", int'(DataOut), 8'hA1);
    InVld  = 1'b1;
    DataIn = 8'hA3;
    step();
    step();
    chk("bp_level_hold", int'(Level), 2);
    chk("bp_data_hold", int'(DataOut), 8'hA1);
    OutRdy = 1'b1;
    send(8'hA3);
    repeat (4) step();
    chk("bp_drained", exp_q.size(), 0);

    // Simultaneous in/out transfer while holding one word
    OutRdy = 1'b0;
    send(8'h10);
    chk("sim_pre_data", int'(DataOut), 8'h10);
    OutRdy = 1'b1;
    send(8'h11);
    chk("sim_data", int'(DataOut), 8'h11);
    chk("sim_level", int'(Level), 1);
    repeat (3) step();
    chk("sim_drained", exp_q.size(), 0);

    // Clear while full, with a word offered upstream
    OutRdy = 1'b0;
    send(8'h55);
    send(8'h66);
    chk("clr_pre_level", int'(Level), 2);
    InVld  = 1'b1;
    DataIn = 8'h77;
    Clear  = 1'b1;
    step();
    Clear = 1'b0;
    InVld = 1'b0;
    exp_q.delete();
    chk("clr_outvld", int'(OutVld), 0);
    chk("clr_dataout", int'(DataOut), 0);
    chk("clr_level", int'(Level), 0);
    chk("clr_inrdy", int'(InRdy), 1);
    OutRdy = 1'b1;
    repeat (3) step();

    // Asynchronous reset between edges while full
    OutRdy = 1'b0;
    send(8'hC1);
    send(8'hC2);
    chk("arst_pre_level", int'(Level), 2);
    @(negedge Clk);
    #2 Rstn = 1'b0;
    #1;
    chk("arst_outvld", int'(OutVld), 0);
    chk("arst_dataout", int'(DataOut), 0);
    chk("arst_inrdy", int'(InRdy), 1);
    chk("arst_level", int'(Level), 0);
    exp_q.delete();
    #1 Rstn = 1'b1;
    step();

    // Random valid/ready traffic
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          send(8'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge Clk);
          #1 OutRdy = 1'($urandom_range(0, 1));
        end
      end
    join
    OutRdy = 1'b1;
    repeat (5) step();
    chk("rand_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
